// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Drives the PC / IF/ID / ID/EX write enables, the ID/EX bubble (do_stall)
// and the IF/ID flush from load-use, taken-branch and data-memory-wait events.
// Control outputs are a same-cycle (Mealy) decode of the state and inputs so a
// hazard is handled ahead of the register capture edge.
// Optional feature macro: HAZARD_STATS_EN builds saturating stall/flush
// counters; when it is undefined, stall_cnt and flush_cnt are tied to zero.
module hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_Mread,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IDEX_write,
    output logic        do_stall,
    output logic        IFID_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } state_e;

    // fcnt counts remaining FLUSH-state cycles after the first one; the
    // branch cycle itself already flushes, so the load value is depth-2.
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_DEPTH - 2);

    state_e     state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       lu;

    // Load in EX whose destination feeds a source of the ID instruction;
    // register 0 never creates a dependency.
    assign lu = ex_Mread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state and same-cycle control decode.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        PC_write   = 1'b1;
        IFID_write = 1'b1;
        IDEX_write = 1'b1;
        do_stall   = 1'b0;
        IFID_flush = 1'b0;
        if (rst) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_write = 1'b0;
            state_d    = RUN;
            fcnt_d     = 2'd0;
        end else if (mem_busy) begin
            // Freeze everything: no bubble, nothing lost. A flush in
            // progress keeps its position and count.
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_write = 1'b0;
            state_d    = (state_q == FLUSH) ? FLUSH : MWAIT;
        end else if (state_q == FLUSH) begin
            // EX holds a bubble here, so a taken branch cannot appear.
            IFID_flush = 1'b1;
            do_stall   = 1'b1;
            if (fcnt_q == 2'd0) begin
                state_d = RUN;
            end else begin
                fcnt_d = fcnt_q - 2'd1;
            end
        end else if (ex_branch_taken) begin
            IFID_flush = 1'b1;
            do_stall   = 1'b1;
            if (FLUSH_DEPTH == 1) begin
                state_d = RUN;
            end else begin
                state_d = FLUSH;
                fcnt_d  = FCNT_INIT;
            end
        end else if (lu && (state_q != BUBBLE)) begin
            // Hold PC and IF/ID one cycle, insert a bubble into ID/EX.
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            do_stall   = 1'b1;
            state_d    = BUBBLE;
        end else begin
            state_d = RUN;
        end
    end

    // State and flush-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        stall_evt;

    // The load-use stall is the only case that holds PC while ID/EX writes.
    assign stall_evt = IDEX_write && !PC_write;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (IFID_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus randomized stimulus against a
// behavioural model of the hazard rules (FLUSH_DEPTH = 3).
module tb_hazard_ctrl;

    localparam int DEPTH = 3;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] exr;
        logic       mr;
        logic       br;
        logic       busy;
        logic [4:0] ctl;      // {PC_write, IFID_write, IDEX_write, do_stall, IFID_flush}
        logic       chk_state;
        logic [1:0] st;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_Mread, ex_branch_taken, mem_busy;
    logic        PC_write, IFID_write, IDEX_write, do_stall, IFID_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_Mread(ex_Mread),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
        .do_stall(do_stall), .IFID_flush(IFID_flush), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // flush_left: flush cycles still owed for the current branch.
    // prev_stall: the previous cycle was a load-use stall (its repeat is masked).
    int   m_flush_left = 0;
    bit   m_prev_stall = 0;
    int   m_state      = 0;
    int   m_scnt       = 0;
    int   m_fcnt       = 0;
    int   e_state, e_scnt, e_fcnt;

    task automatic model_step(input vec_t v);
        bit lu;
        logic [4:0] c;
        e_state = m_state;
        e_scnt  = m_scnt;
        e_fcnt  = m_fcnt;
        lu = v.mr && (v.exr != 0) && ((v.exr == v.rs) || (v.urt && v.exr == v.rt));
        if (v.rst) begin
            c = 5'b00000;
            m_flush_left = 0; m_prev_stall = 0; m_state = 0; m_scnt = 0; m_fcnt = 0;
        end else if (v.busy) begin
            c = 5'b00000;
            m_prev_stall = 0;
            m_state = (m_flush_left > 0) ? 2 : 3;
        end else if (m_flush_left > 0) begin
            c = 5'b11111;
            m_flush_left--;
            m_prev_stall = 0;
            m_state = (m_flush_left > 0) ? 2 : 0;
        end else if (v.br) begin
            c = 5'b11111;
            m_flush_left = DEPTH - 1;
            m_prev_stall = 0;
            m_state = (m_flush_left > 0) ? 2 : 0;
        end else if (lu && !m_prev_stall) begin
            c = 5'b00110;
            m_prev_stall = 1;
            m_state = 1;
        end else begin
            c = 5'b11100;
            m_prev_stall = 0;
            m_state = 0;
        end
        if (!v.rst) begin
            if (c == 5'b00110 && m_scnt < 16'hFFFF) m_scnt++;
            if (c[0] && m_fcnt < 16'hFFFF) m_fcnt++;
        end
        exp_q.push_back(c);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt;
        ex_rt = v.exr; ex_Mread = v.mr; ex_branch_taken = v.br; mem_busy = v.busy;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        logic [4:0] m_ctl, e_ctl, act;
        @(negedge clk);
        drive(v);
        #2;
        model_step(v);
        m_ctl = exp_q.pop_front();
        e_ctl = use_tbl ? v.ctl : m_ctl;
        act = {PC_write, IFID_write, IDEX_write, do_stall, IFID_flush};
        check({tag, " PC_write"},   16'(act[4]), 16'(e_ctl[4]));
        check({tag, " IFID_write"}, 16'(act[3]), 16'(e_ctl[3]));
        check({tag, " IDEX_write"}, 16'(act[2]), 16'(e_ctl[2]));
        check({tag, " do_stall"},   16'(act[1]), 16'(e_ctl[1]));
        check({tag, " IFID_flush"}, 16'(act[0]), 16'(e_ctl[0]));
        if (!use_tbl || v.chk_state) begin
            check({tag, " state"}, 16'(state), use_tbl ? 16'(v.st) : 16'(e_state));
`ifdef HAZARD_STATS_EN
            check({tag, " stall_cnt"}, stall_cnt, 16'(e_scnt));
            check({tag, " flush_cnt"}, flush_cnt, 16'(e_fcnt));
`else
            check({tag, " stall_cnt"}, stall_cnt, 16'd0);
            check({tag, " flush_cnt"}, flush_cnt, 16'd0);
`endif
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] exr, input logic mr,
                                input logic br, input logic busy, input logic [4:0] ctl,
                                input logic cs, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.urt = urt; v.exr = exr; v.mr = mr;
        v.br = br; v.busy = busy; v.ctl = ctl; v.chk_state = cs; v.st = st;
        return v;
    endfunction

    // Shorthands: idle / busy / branch / load-use input patterns.
    function automatic vec_t idl(input logic [4:0] ctl, input logic [1:0] st);
        return mk(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, ctl, 1, st);
    endfunction
    function automatic vec_t bsy(input logic [1:0] st);
        return mk(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 1, 5'b00000, 1, st);
    endfunction

    localparam logic [4:0] NORM = 5'b11100;
    localparam logic [4:0] FLSH = 5'b11111;
    localparam logic [4:0] STAL = 5'b00110;

    vec_t tbl[$];
    vec_t rv;

    initial begin
        // Reset with branch and busy asserted: all controls low.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 5'b00000, 1, 0));
        tbl.push_back(idl(NORM, 0));
        // Load-use on rs: one bubble, then masked.
        tbl.push_back(mk(0, 5'd5, 5'd2, 0, 5'd5, 1, 0, 0, STAL, 1, 0));
        tbl.push_back(mk(0, 5'd5, 5'd2, 0, 5'd5, 1, 0, 0, NORM, 1, 1));
        tbl.push_back(idl(NORM, 0));
        // ex_rt = 0 never stalls.
        tbl.push_back(mk(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, NORM, 1, 0));
        // Load-use on rt, and rt ignored when not a source.
        tbl.push_back(mk(0, 5'd1, 5'd7, 1, 5'd7, 1, 0, 0, STAL, 1, 0));
        tbl.push_back(idl(NORM, 1));
        tbl.push_back(mk(0, 5'd1, 5'd7, 0, 5'd7, 1, 0, 0, NORM, 1, 0));
        // Taken branch: exactly 3 flush cycles.
        tbl.push_back(mk(0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, FLSH, 1, 0));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(NORM, 0));
        // Busy for 4 cycles during the 2nd flush cycle.
        tbl.push_back(mk(0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, FLSH, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bsy(2));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(NORM, 0));
        // Branch and load-use together: branch wins.
        tbl.push_back(mk(0, 5'd5, 5'd2, 0, 5'd5, 1, 1, 0, FLSH, 1, 0));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(FLSH, 2));
        tbl.push_back(idl(NORM, 0));
        // Busy from RUN, then load-use on release (MWAIT behaves as RUN).
        tbl.push_back(bsy(0));
        tbl.push_back(bsy(3));
        tbl.push_back(mk(0, 5'd5, 5'd2, 0, 5'd5, 1, 0, 0, STAL, 1, 3));
        tbl.push_back(idl(NORM, 1));
        // Reset aborts a flush sequence.
        tbl.push_back(mk(0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, FLSH, 1, 0));
        tbl.push_back(mk(1, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 5'b00000, 1, 2));
        tbl.push_back(idl(NORM, 0));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            rv = mk($urandom_range(0, 39) == 0, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                    5'b0, 1, 0);
            run_cycle(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
